// File: rtl/fpu_rr_sched_if.sv
// Bundle of every handshake/bus signal around the FPU scheduler.
// The master modport is the scheduler itself, and the slave modport is the
// surrounding logic: the two requesters, the add/sub unit, the multiplier
// and the response consumers.
//
// Handshake rules on every channel:
// - A valid stays high until it is taken.
// - Nothing in the payload changes while valid is high.
// - A transfer happens on a rising clock edge where valid and ready are
//   both high. A yumi counts as the ready of the matching valid.
interface fpu_rr_sched_if #(
    parameter int e_p = 8,
    parameter int m_p = 23
);
    localparam int w = e_p + m_p + 1;

    // requester side
    logic [1:0]        req_v_i;
    logic [1:0][1:0]   req_op_i;
    logic [1:0][w-1:0] req_a_i;
    logic [1:0][w-1:0] req_b_i;
    logic [1:0]        req_ready_o;

    // shared operand bus towards both units
    logic [w-1:0]      fu_a_o;
    logic [w-1:0]      fu_b_o;

    // add/sub unit
    logic              add_v_o;
    logic              add_sub_o;
    logic              add_ready_i;
    logic              add_res_v_i;
    logic [w-1:0]      add_z_i;
    logic [3:0]        add_flags_i;
    logic              add_yumi_o;

    // multiplier
    logic              mul_v_o;
    logic              mul_ready_i;
    logic              mul_res_v_i;
    logic [w-1:0]      mul_z_i;
    logic [3:0]        mul_flags_i;
    logic              mul_yumi_o;

    // response side
    logic [1:0]        resp_v_o;
    logic [w-1:0]      resp_z_o;
    logic [3:0]        resp_flags_o;
    logic [1:0]        resp_yumi_i;

    logic              busy_o;

    modport master (
        input  req_v_i, req_op_i, req_a_i, req_b_i,
        output req_ready_o,
        output fu_a_o, fu_b_o,
        output add_v_o, add_sub_o, input add_ready_i,
        input  add_res_v_i, add_z_i, add_flags_i, output add_yumi_o,
        output mul_v_o, input mul_ready_i,
        input  mul_res_v_i, mul_z_i, mul_flags_i, output mul_yumi_o,
        output resp_v_o, resp_z_o, resp_flags_o, input resp_yumi_i,
        output busy_o
    );

    modport slave (
        output req_v_i, req_op_i, req_a_i, req_b_i,
        input  req_ready_o,
        input  fu_a_o, fu_b_o,
        input  add_v_o, add_sub_o, output add_ready_i,
        output add_res_v_i, add_z_i, add_flags_i, input add_yumi_o,
        input  mul_v_o, output mul_ready_i,
        output mul_res_v_i, mul_z_i, mul_flags_i, input mul_yumi_o,
        input  resp_v_o, resp_z_o, resp_flags_o, output resp_yumi_i,
        input  busy_o
    );
endinterface

// File: rtl/fpu_rr_sched.sv
// Two-requester round-robin scheduler for a shared add/sub unit and a shared
// multiplier. At most one operation is in flight at a time. Illegal ops
// (11) are accepted and answered with an unimplemented flag, and no unit is
// ever started for them. state_o shows the FSM state for debug.
module fpu_rr_sched #(
    parameter int e_p = 8,
    parameter int m_p = 23
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    fpu_rr_sched_if.master        bus,
    output logic [1:0]            state_o
);
    localparam int w = e_p + m_p + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    state_t       state_q, state_d;
    logic         id_q, id_d;
    logic [1:0]   op_q, op_d;
    logic [w-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic [3:0]   flags_q, flags_d;
    logic         last_q, last_d;

    logic         grant_v;
    logic         grant_id;
    logic         is_mul;

    logic [1:0]   req_ready;
    logic         add_v, add_sub, add_yumi;
    logic         mul_v, mul_yumi;
    logic [1:0]   resp_v;
    logic [w-1:0] resp_z;
    logic [3:0]   resp_flags;

    assign is_mul = (op_q == OP_MUL);

    // Arbitration: the grant goes to the requester not served last when both ask.
    // With a single requester, that requester wins. While reset is held,
    // no grant is possible, so req_ready_o stays 0.
    always_comb begin
        grant_v  = reset_i && (state_q == IDLE) && (|bus.req_v_i);
        grant_id = 1'b0;
        if (&bus.req_v_i) begin
            grant_id = ~last_q;
        end else begin
            grant_id = bus.req_v_i[1];
        end
    end

    // Next-state and output decode; every output defaults to 0.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        z_d        = z_q;
        flags_d    = flags_q;
        last_d     = last_q;
        req_ready  = 2'b00;
        add_v      = 1'b0;
        add_sub    = 1'b0;
        add_yumi   = 1'b0;
        mul_v      = 1'b0;
        mul_yumi   = 1'b0;
        resp_v     = 2'b00;
        resp_z     = '0;
        resp_flags = 4'b0000;

        unique case (state_q)
            IDLE: begin
                if (grant_v) begin
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    id_d      = grant_id;
                    op_d      = bus.req_op_i[grant_id];
                    a_d       = bus.req_a_i[grant_id];
                    b_d       = bus.req_b_i[grant_id];
                    last_d    = grant_id;
                    if (bus.req_op_i[grant_id] == OP_ILL) begin
                        z_d     = '0;
                        flags_d = 4'b1000;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (is_mul) begin
                    mul_v = 1'b1;
                    if (bus.mul_ready_i) state_d = WAIT;
                end else begin
                    add_v   = 1'b1;
                    add_sub = (op_q == OP_SUB);
                    if (bus.add_ready_i) state_d = WAIT;
                end
            end
            WAIT: begin
                // Results from the unit that was not started are ignored.
                if (is_mul) begin
                    if (bus.mul_res_v_i) begin
                        mul_yumi = 1'b1;
                        z_d      = bus.mul_z_i;
                        flags_d  = bus.mul_flags_i;
                        state_d  = RESP;
                    end
                end else begin
                    if (bus.add_res_v_i) begin
                        add_yumi = 1'b1;
                        z_d      = bus.add_z_i;
                        flags_d  = bus.add_flags_i;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                resp_v     = id_q ? 2'b10 : 2'b01;
                resp_z     = z_q;
                resp_flags = flags_q;
                if (bus.resp_yumi_i[id_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any op that is in flight.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            flags_q <= 4'b0000;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            flags_q <= flags_d;
            last_q  <= last_d;
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.fu_a_o       = a_q;
    assign bus.fu_b_o       = b_q;
    assign bus.add_v_o      = add_v;
    assign bus.add_sub_o    = add_sub;
    assign bus.add_yumi_o   = add_yumi;
    assign bus.mul_v_o      = mul_v;
    assign bus.mul_yumi_o   = mul_yumi;
    assign bus.resp_v_o     = resp_v;
    assign bus.resp_z_o     = resp_z;
    assign bus.resp_flags_o = resp_flags;
    assign bus.busy_o       = (state_q != IDLE);
    assign state_o          = state_q;

endmodule

// File: tb/tb_fpu_rr_sched.sv
// Directed bench for fpu_rr_sched. The bench plays both requesters, both
// arithmetic units and the response consumer. Unit results are the
// hand-computed IEEE-754 single values for each vector.
module tb_fpu_rr_sched;
    logic       clk_i;
    logic       reset_i;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    fpu_rr_sched_if #(.e_p(8), .m_p(23)) bus_if ();

    fpu_rr_sched #(.e_p(8), .m_p(23)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus_if.master),
        .state_o (state_o)
    );

    // clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_inputs();
        bus_if.req_v_i     = 2'b00;
        bus_if.req_op_i    = '0;
        bus_if.req_a_i     = '0;
        bus_if.req_b_i     = '0;
        bus_if.add_ready_i = 1'b0;
        bus_if.add_res_v_i = 1'b0;
        bus_if.add_z_i     = '0;
        bus_if.add_flags_i = 4'b0000;
        bus_if.mul_ready_i = 1'b0;
        bus_if.mul_res_v_i = 1'b0;
        bus_if.mul_z_i     = '0;
        bus_if.mul_flags_i = 4'b0000;
        bus_if.resp_yumi_i = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {30'd0, bus_if.req_ready_o}, 32'd0);
        check({tag, "_units"}, {28'd0, bus_if.add_v_o, bus_if.add_sub_o,
                                bus_if.mul_v_o, bus_if.busy_o}, 32'd0);
        check({tag, "_yumi"}, {30'd0, bus_if.add_yumi_o, bus_if.mul_yumi_o}, 32'd0);
        check({tag, "_resp"}, {26'd0, bus_if.resp_v_o, bus_if.resp_flags_o}, 32'd0);
        check({tag, "_rz"}, bus_if.resp_z_o, 32'd0);
        check({tag, "_fua"}, bus_if.fu_a_o, 32'd0);
        check({tag, "_fub"}, bus_if.fu_b_o, 32'd0);
    endtask

    // One full request from requester k. ready_lat is the number of cycles
    // the unit holds ready low; res_lat is the number of cycles before its
    // result appears. Meanwhile the other unit shows a junk result, which
    // the DUT must ignore.
    task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ready_lat, input int res_lat,
                          input logic [31:0] z, input logic [3:0] fl,
                          input logic [31:0] exp_z, input logic [3:0] exp_fl);
        logic [1:0] onehot;
        bit         mul;
        onehot = (k == 1) ? 2'b10 : 2'b01;
        mul    = (op == 2'b10);
        @(negedge clk_i);
        bus_if.req_v_i[k]  = 1'b1;
        bus_if.req_op_i[k] = op;
        bus_if.req_a_i[k]  = a;
        bus_if.req_b_i[k]  = b;
        #1;
        check("grant", {30'd0, bus_if.req_ready_o}, {30'd0, onehot});
        @(posedge clk_i);
        @(negedge clk_i);
        bus_if.req_v_i[k] = 1'b0;
        #1;
        check("ready_busy", {30'd0, bus_if.req_ready_o}, 32'd0);
        check("busy", {31'd0, bus_if.busy_o}, 32'd1);
        check("fu_a", bus_if.fu_a_o, a);
        check("fu_b", bus_if.fu_b_o, b);
        if (op == 2'b11) begin
            check("ill_nounit", {30'd0, bus_if.add_v_o, bus_if.mul_v_o}, 32'd0);
        end else begin
            for (int i = 0; i <= ready_lat; i++) begin
                if (i == ready_lat) begin
                    bus_if.add_ready_i = 1'b1;
                    bus_if.mul_ready_i = 1'b1;
                end
                #1;
                check("unit_v", {30'd0, bus_if.add_v_o, bus_if.mul_v_o},
                      mul ? 32'd1 : 32'd2);
                check("add_sub", {31'd0, bus_if.add_sub_o}, (op == 2'b01) ? 32'd1 : 32'd0);
                check("fu_a_hold", bus_if.fu_a_o, a);
                @(posedge clk_i);
                @(negedge clk_i);
            end
            bus_if.add_ready_i = 1'b0;
            bus_if.mul_ready_i = 1'b0;
            #1;
            check("unit_v_off", {30'd0, bus_if.add_v_o, bus_if.mul_v_o}, 32'd0);
            for (int i = 0; i <= res_lat; i++) begin
                bus_if.add_res_v_i = 1'b1;
                bus_if.mul_res_v_i = 1'b1;
                bus_if.add_z_i     = mul ? 32'hDEADBEEF : z;
                bus_if.mul_z_i     = mul ? z : 32'hDEADBEEF;
                bus_if.add_flags_i = mul ? 4'b1111 : fl;
                bus_if.mul_flags_i = mul ? fl : 4'b1111;
                if (i != res_lat) begin
                    if (mul) bus_if.mul_res_v_i = 1'b0;
                    else     bus_if.add_res_v_i = 1'b0;
                end
                #1;
                check("yumi", {30'd0, bus_if.add_yumi_o, bus_if.mul_yumi_o},
                      (i != res_lat) ? 32'd0 : (mul ? 32'd1 : 32'd2));
                @(posedge clk_i);
                @(negedge clk_i);
            end
            bus_if.add_res_v_i = 1'b0;
            bus_if.mul_res_v_i = 1'b0;
        end
        #1;
        check("resp_v", {30'd0, bus_if.resp_v_o}, {30'd0, onehot});
        check("resp_z", bus_if.resp_z_o, exp_z);
        check("resp_fl", {28'd0, bus_if.resp_flags_o}, {28'd0, exp_fl});
        // yumi on the other bit must not retire the response
        bus_if.resp_yumi_i = ~onehot;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("resp_hold", {30'd0, bus_if.resp_v_o}, {30'd0, onehot});
        bus_if.resp_yumi_i = onehot;
        @(posedge clk_i);
        @(negedge clk_i);
        bus_if.resp_yumi_i = 2'b00;
        #1;
        check("back_idle", {30'd0, bus_if.busy_o, bus_if.resp_v_o[0] | bus_if.resp_v_o[1]}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset_i = 1'b0;
        bus_if.req_v_i = 2'b11;
        repeat (2) @(negedge clk_i);
        #1;
        check_all_zero("reset");
        check("reset_state", {30'd0, state_o}, 32'd0);
        bus_if.req_v_i = 2'b00;
        @(negedge clk_i);
        reset_i = 1'b1;

        // 3.0 + 3.0 = 6.0
        run_op(0, 2'b00, 32'h40400000, 32'h40400000, 0, 0,
               32'h40C00000, 4'b0000, 32'h40C00000, 4'b0000);
        // 3.0 - 3.0 = +0.0
        run_op(1, 2'b01, 32'h40400000, 32'h40400000, 0, 1,
               32'h00000000, 4'b0000, 32'h00000000, 4'b0000);
        // 2.0 * 1.5 = 3.0; the multiplier stalls for 3 cycles
        run_op(0, 2'b10, 32'h40000000, 32'h3FC00000, 3, 2,
               32'h40400000, 4'b0000, 32'h40400000, 4'b0000);
        // illegal op
        run_op(1, 2'b11, 32'h12345678, 32'h9ABCDEF0, 0, 0,
               32'h0, 4'b0000, 32'h00000000, 4'b1000);

        // reset while waiting for an add result
        @(negedge clk_i);
        bus_if.req_v_i[0]  = 1'b1;
        bus_if.req_op_i[0] = 2'b00;
        bus_if.req_a_i[0]  = 32'h3F800000;
        bus_if.req_b_i[0]  = 32'h3F800000;
        bus_if.add_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus_if.req_v_i = 2'b00;
        @(posedge clk_i);
        @(negedge clk_i);
        bus_if.add_ready_i = 1'b0;
        #1;
        check("pre_rst_state", {30'd0, state_o}, 32'd2);
        reset_i = 1'b0;
        #1;
        check_all_zero("rst_wait");
        @(negedge clk_i);
        reset_i = 1'b1;
        bus_if.add_res_v_i = 1'b1;
        bus_if.add_z_i     = 32'h40000000;
        #1;
        check("late_yumi", {30'd0, bus_if.add_yumi_o, bus_if.mul_yumi_o}, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("late_noresp", {29'd0, bus_if.resp_v_o, bus_if.busy_o}, 32'd0);
        bus_if.add_res_v_i = 1'b0;

        // contention: the pointer starts at 1 after reset, so grants go 0,1,0,1
        exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
        bus_if.req_op_i    = '0;
        bus_if.req_a_i[0]  = 32'h3F800000;
        bus_if.req_a_i[1]  = 32'h40000000;
        bus_if.add_ready_i = 1'b1;
        bus_if.add_res_v_i = 1'b1;
        bus_if.add_z_i     = 32'h40000000;
        bus_if.resp_yumi_i = 2'b11;
        bus_if.req_v_i     = 2'b11;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            #1;
            if (bus_if.busy_o) begin
                check("no_ready_busy", {30'd0, bus_if.req_ready_o}, 32'd0);
            end else if (bus_if.req_ready_o != 2'b00) begin
                check("rr_grant", {30'd0, bus_if.req_ready_o},
                      (exp_q[0] == 32'd1) ? 32'd2 : 32'd1);
                void'(exp_q.pop_front());
            end
            @(negedge clk_i);
        end
        check("rr_all_granted", exp_q.size(), 32'd0);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_rr_sched.md
FPU_RR_SCHED -- requirements
Module: fpu_rr_sched

Interface
REQ-001 Parameter e_p, default 8, exponent width; m_p, default 23, mantissa width; w = e_p+m_p+1.
REQ-002 clk_i  in  1  sole clock; all state on rising edge.
REQ-003 reset_i  in  1  reset, asynchronous, active-low.
REQ-004 req_v_i  in  2  per-requester request valid.
REQ-005 req_op_i  in  2x2  per-requester op: 00 add, 01 sub, 10 mul, 11 illegal.
REQ-006 req_a_i, req_b_i  in  2xw each  per-requester operands.
REQ-007 req_ready_o  out  2  one-hot accept pulse; request taken when req_v_i[k]&req_ready_o[k].
REQ-008 fu_a_o, fu_b_o  out  w each  registered operands, shared by both units.
REQ-009 add_v_o, add_sub_o  out  1 each  add/sub unit valid and subtract select; add_ready_i  in  1.
REQ-010 mul_v_o  out  1  multiplier valid; mul_ready_i  in  1.
REQ-011 add_res_v_i, mul_res_v_i  in  1 each; add_z_i, mul_z_i  in  w each; add_flags_i, mul_flags_i  in  4 each {unimpl,invalid,ovf,unf}.
REQ-012 add_yumi_o, mul_yumi_o  out  1 each  result consume strobes.
REQ-013 resp_v_o  out  2  one-hot response valid; resp_z_o  out  w; resp_flags_o  out  4; resp_yumi_i  in  2.
REQ-014 busy_o  out  1  high whenever state != IDLE.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; at most one operation outstanding.
REQ-016 IDLE: if any req_v_i with legal op, grant one requester, pulse req_ready_o for that cycle, latch operands, op, id; next state ISSUE.
REQ-017 Round-robin: both valid -> grant the requester not granted last; last-grant pointer resets to 1 (first contention grants 0); updates only on grant.
REQ-018 Illegal op (11): accepted as any request, not issued; goes to RESP with resp_z_o=0, flags=4'b1000, then IDLE.
REQ-019 ISSUE: assert add_v_o (add_sub_o=1 for sub) or mul_v_o, operands stable; exit to WAIT on the cycle v&ready; hold otherwise.
REQ-020 WAIT: on selected unit's res_v_i, capture z and flags, pulse that unit's yumi_o same cycle; next state RESP. Result valid from the non-selected unit ignored, its yumi_o stays 0.
REQ-021 RESP: resp_v_o[id]=1 with captured z/flags until resp_yumi_i[id]; then IDLE. resp_yumi_i on the non-owning bit ignored.
REQ-022 No request accepted outside IDLE; req_ready_o=0 in ISSUE/WAIT/RESP.
REQ-023 Minimum turnaround: accept (cycle 0), issue cycle 1, result capture at first cycle unit returns, response next cycle; back-to-back requests re-enter IDLE one cycle after resp_yumi_i.
REQ-024 Only one of add_v_o/mul_v_o high at a time; both 0 outside ISSUE.
REQ-025 fu_a_o/fu_b_o change only on grant.

Reset
REQ-026 reset_i low asynchronously forces IDLE; all outputs 0: req_ready_o, add_v_o, add_sub_o, mul_v_o, yumi strobes, resp_v_o, resp_z_o, resp_flags_o, fu_a_o, fu_b_o, busy_o; pointer=1.
REQ-027 Reset mid-operation abandons the outstanding op with no response; a late unit result after reset release in IDLE is ignored (no yumi).

Verification
REQ-028 Req0 add a=0x40400000 b=0x40400000, ready high -> add_v_o for one cycle, resp_v_o=2'b01, resp_z_o=0x40C00000.
REQ-029 Req1 sub a=0x40400000 b=0x40400000 -> add_sub_o=1, resp_v_o=2'b10, resp_z_o=0x00000000.
REQ-030 Req0 mul a=0x40000000 b=0x3FC00000, mul_ready_i low 3 cycles -> mul_v_o held 4 cycles, operands stable, resp_z_o=0x40400000.
REQ-031 Both requesters valid continuously for 4 ops -> grant order 0,1,0,1; no req_ready_o outside IDLE.
REQ-032 req_op_i=11 -> no unit valid, resp_flags_o=4'b1000, resp_z_o=0.
REQ-033 reset_i low during WAIT -> all outputs 0 immediately; subsequent add_res_v_i produces no yumi and no response.
